// File: rtl/stage_mem.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit controller port,
// non-memory instructions pass straight through to MEM/WB.
module stage_mem (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] mem_addr_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic        stall_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stall_req_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_a_o,
   output logic [7:0]  mem_dout_o,
   input  logic        mem_gnt_i,
   input  logic [7:0]  mem_din_i
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned BW   = 8;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {IDLE, ACC, LAST, DONE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [1:0]           k;
   logic [1:0]           k_nxt;
   logic [3:0][BW-1:0]   lane_q;
   logic                 cap_pend;
   logic [1:0]           cap_lane;
   logic                 is_load;
   logic                 is_store;
   logic                 size_ok;
   logic                 mem_op;
   logic [1:0]           last_k;
   logic [XLEN-1:0]      load_val;

   // Instruction decode: byte count comes from funct3, unknown sizes are not memory ops
   always_comb begin
      is_load  = (opcode_i == OP_LOAD);
      is_store = (opcode_i == OP_STORE);
      size_ok  = 1'b1;
      last_k   = 2'd0;
      case (funct3_i)
         3'b000, 3'b100: last_k = 2'd0;
         3'b001, 3'b101: last_k = 2'd1;
         3'b010:         last_k = 2'd3;
         default:        size_ok = 1'b0;
      endcase
      mem_op = (is_load || is_store) && size_ok;
   end

   // Next-state and byte counter
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      if (rdy) begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  state_nxt = ACC;
                  k_nxt     = 2'd0;
               end
            end
            ACC: begin
               if (mem_gnt_i) begin
                  k_nxt = k + 2'd1;
                  if (k == last_k) begin
                     state_nxt = is_load ? LAST : DONE;
                  end
               end
            end
            LAST: state_nxt = DONE;
            DONE: begin
               // holding here while frozen keeps a store from being replayed
               if (!stall_i) begin
                  state_nxt = IDLE;
                  k_nxt     = 2'd0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, counter and load buffer; read data lands one cycle after its grant
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         k        <= 2'd0;
         lane_q   <= '0;
         cap_pend <= 1'b0;
         cap_lane <= 2'd0;
      end else if (rdy) begin
         state    <= state_nxt;
         k        <= k_nxt;
         if (cap_pend) begin
            lane_q[cap_lane] <= mem_din_i;
         end
         cap_pend <= (state == ACC) && is_load && mem_gnt_i;
         cap_lane <= k;
      end
   end

   // Little-endian assembly with sign/zero extension
   always_comb begin
      case (funct3_i)
         3'b000:  load_val = {{24{lane_q[0][7]}}, lane_q[0]};
         3'b100:  load_val = {24'h0, lane_q[0]};
         3'b001:  load_val = {{16{lane_q[1][7]}}, lane_q[1], lane_q[0]};
         3'b101:  load_val = {16'h0, lane_q[1], lane_q[0]};
         default: load_val = lane_q;
      endcase
   end

   // Pipeline and memory-port outputs; reset forces everything to zero
   always_comb begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      stall_req_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_a_o     = '0;
      mem_dout_o  = '0;
      if (!rst) begin
         wd_o = wd_i;
         if (!mem_op) begin
            wreg_o  = wreg_i && !(is_load || is_store);
            wdata_o = wdata_i;
         end else if (state == DONE) begin
            wreg_o  = wreg_i;
            wdata_o = is_load ? load_val : wdata_i;
         end else begin
            stall_req_o = 1'b1;
         end
         if (mem_op && (state == ACC)) begin
            mem_req_o  = rdy;
            mem_we_o   = is_store;
            mem_a_o    = mem_addr_i + XLEN'(k);
            mem_dout_o = wdata_i[{k, 3'b000} +: BW];
         end
      end
   end
endmodule

// File: tb/tb_stage_mem.sv
// Scoreboarded random bench for stage_mem with a byte-addressed memory model
// acting as the controller and a word-level reference model for results.
module tb_stage_mem;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ADD   = 7'b0110011;
   localparam logic [6:0] OP_NOP   = 7'b0010011;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } res_t;

   logic        clk;
   logic        rst, rdy, stall_i, wreg_i, wreg_o, stall_req_o;
   logic        mem_req_o, mem_we_o, mem_gnt_i;
   logic [6:0]  opcode_i;
   logic [2:0]  funct3_i;
   logic [31:0] mem_addr_i, wdata_i, wdata_o, mem_a_o;
   logic [4:0]  wd_i, wd_o;
   logic [7:0]  mem_dout_o, mem_din_i;

   int checks = 0;
   int errors = 0;
   int op_id = 0;
   bit present = 1'b0;
   int unsigned grant_pct = 100;
   int unsigned rdy_low_pct = 0;
   bit gnt_force[$];
   int deny_cnt = 0, req_cnt = 0, gnt_cnt = 0, wr_cnt = 0, exp_wr_cnt = 0;
   res_t exp_q[$];
   logic [7:0] ref_mem [logic [31:0]];
   logic [7:0] dut_mem [logic [31:0]];

   stage_mem dut (
      .clk(clk), .rst(rst), .rdy(rdy), .opcode_i(opcode_i), .funct3_i(funct3_i),
      .mem_addr_i(mem_addr_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .stall_i(stall_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .stall_req_o(stall_req_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_gnt_i(mem_gnt_i),
      .mem_din_i(mem_din_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] rd_ref(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] rd_dut(input logic [31:0] a);
      return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
   endfunction

   function automatic int nbytes(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic pick_rdy();
      return $urandom_range(0, 99) >= rdy_low_pct;
   endfunction

   // Word-level reference: what MEM/WB should receive, and the memory after a store
   function automatic res_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [4:0] wd,
                                  input logic wr, input logic [31:0] wdata);
      res_t r;
      int n;
      logic [31:0] v;
      n = nbytes(f3);
      v = 32'h0;
      r.wd = wd;
      r.wreg = wr;
      r.wdata = wdata;
      if ((op == OP_LOAD || op == OP_STORE) && n == 0) begin
         r.wreg = 1'b0;
      end else if (op == OP_LOAD) begin
         for (int i = 0; i < n; i++) v = v | (32'(rd_ref(addr + 32'(i))) << (8 * i));
         if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
         if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
         r.wdata = v;
      end else if (op == OP_STORE) begin
         for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * i));
         exp_wr_cnt += n;
      end
      return r;
   endfunction

   task automatic finish_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the DUT", name);
      finish_run();
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      ref_mem[a] = d;
      dut_mem[a] = d;
   endtask

   // Memory controller model: grants requests, writes bytes, returns read data next cycle
   initial begin : ctrl
      logic        rd_pend;
      logic [31:0] rd_addr;
      rd_pend = 1'b0;
      rd_addr = '0;
      mem_gnt_i = 1'b0;
      mem_din_i = '0;
      forever begin
         @(negedge clk);
         rd_pend = 1'b0;
         mem_gnt_i = 1'b0;
         if (mem_req_o) begin
            req_cnt++;
            if (gnt_force.size() > 0) mem_gnt_i = gnt_force.pop_front();
            else mem_gnt_i = ($urandom_range(0, 99) < grant_pct);
            if (!mem_gnt_i) begin
               deny_cnt++;
            end else begin
               gnt_cnt++;
               if (mem_we_o) begin
                  dut_mem[mem_a_o] = mem_dout_o;
                  wr_cnt++;
               end else begin
                  rd_pend = 1'b1;
                  rd_addr = mem_a_o;
               end
            end
         end
         @(posedge clk);
         #1;
         if (rd_pend) mem_din_i = rd_dut(rd_addr);
      end
   end

   // Monitor: compares every cycle the stage presents a result to MEM/WB
   initial begin : mon
      res_t cur;
      int   cur_id;
      cur = '0;
      cur_id = -1;
      forever begin
         @(negedge clk);
         if (present && !rst && !stall_req_o) begin
            if (cur_id != op_id) begin
               cur_id = op_id;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard: result for op %0d with nothing expected", op_id);
               end else begin
                  cur = exp_q.pop_front();
               end
            end
            checks++;
            if ({wd_o, wreg_o, wdata_o} !== cur) begin
               errors++;
               $display("FAIL result op %0d: got wd=%0d wreg=%0b wdata=%h, expected wd=%0d wreg=%0b wdata=%h",
                        op_id, wd_o, wreg_o, wdata_o, cur.wd, cur.wreg, cur.wdata);
            end
         end
      end
   end

   task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [4:0] wd, input logic wr, input logic [31:0] wdata,
                        input int hold, input bit use_exp, input logic [31:0] exp_wdata);
      res_t r;
      int n, stall_cnt, rdylow, hold_left, base, guard;
      bit memop;
      n = nbytes(f3);
      memop = (op == OP_LOAD || op == OP_STORE) && n > 0;
      @(posedge clk);
      #1;
      opcode_i = op; funct3_i = f3; mem_addr_i = addr;
      wd_i = wd; wreg_i = wr; wdata_i = wdata;
      r = model(op, f3, addr, wd, wr, wdata);
      if (use_exp) r.wdata = exp_wdata;
      exp_q.push_back(r);
      hold_left = memop ? hold : 0;
      stall_i = (hold_left > 0);
      rdy = pick_rdy();
      deny_cnt = 0;
      req_cnt = 0;
      op_id++;
      present = 1'b1;
      stall_cnt = 0;
      rdylow = 0;
      forever begin
         @(negedge clk);
         if (!stall_req_o) break;
         stall_cnt++;
         if (!rdy) rdylow++;
         if (stall_cnt > 300) timeout("stall_release");
         @(posedge clk);
         #1;
         rdy = pick_rdy();
      end
      guard = 0;
      if (memop) begin
         while (!(rdy && !stall_i)) begin
            if (rdy) hold_left--;
            @(posedge clk);
            #1;
            stall_i = (hold_left > 0);
            rdy = pick_rdy();
            @(negedge clk);
            check("done_hold_stall_req", 32'(stall_req_o), 32'd0);
            guard++;
            if (guard > 300) timeout("done_exit");
         end
      end
      #1;
      base = !memop ? 0 : ((op == OP_LOAD) ? n + 2 : n + 1);
      check("stall_cycles", 32'(stall_cnt), 32'(base + deny_cnt + rdylow));
      check("request_cycles", 32'(req_cnt), memop ? 32'(n + deny_cnt) : 32'd0);
   endtask

   initial begin : drv
      int wr0, gc0, guard;
      rst = 1'b1; rdy = 1'b1; stall_i = 1'b0;
      opcode_i = OP_STORE; funct3_i = 3'b010; mem_addr_i = 32'h40;
      wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hA5A5A5A5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_wdata", wdata_o, 32'h0);
      check("reset_mem_a", mem_a_o, 32'h0);
      check("reset_ctrl", 32'({wd_o, wreg_o, stall_req_o, mem_req_o, mem_we_o, mem_dout_o}), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      opcode_i = OP_NOP;

      do_op(OP_ADD, 3'b000, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 1'b0, 32'h0);
      do_op(OP_STORE, 3'b010, 32'h100, 5'd3, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h0);
      check("sw_bytes", {rd_dut(32'h103), rd_dut(32'h102), rd_dut(32'h101), rd_dut(32'h100)}, 32'hDEADBEEF);

      preload(32'h3, 8'h80);
      do_op(OP_LOAD, 3'b000, 32'h3, 5'd10, 1'b1, 32'h0, 0, 1'b1, 32'hFFFFFF80);
      do_op(OP_LOAD, 3'b100, 32'h3, 5'd11, 1'b1, 32'h0, 0, 1'b1, 32'h00000080);

      preload(32'hFFFFFFFF, 8'h34);
      preload(32'h0, 8'h92);
      gnt_force = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_op(OP_LOAD, 3'b001, 32'hFFFFFFFF, 5'd12, 1'b1, 32'h0, 0, 1'b1, 32'hFFFF9234);

      wr0 = wr_cnt;
      do_op(OP_STORE, 3'b000, 32'h180, 5'd0, 1'b0, 32'h000000C3, 3, 1'b0, 32'h0);
      check("sb_single_write", 32'(wr_cnt - wr0), 32'd1);
      check("sb_byte", 32'(rd_dut(32'h180)), 32'hC3);

      // Reset in the middle of a word load, on its third byte
      preload(32'h300, 8'h78);
      preload(32'h301, 8'h56);
      preload(32'h302, 8'h34);
      preload(32'h303, 8'h12);
      @(posedge clk);
      #1;
      present = 1'b0;
      opcode_i = OP_LOAD; funct3_i = 3'b010; mem_addr_i = 32'h300;
      wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h0; stall_i = 1'b0; rdy = 1'b1;
      gc0 = gnt_cnt;
      guard = 0;
      forever begin
         @(posedge clk);
         #2;
         if (gnt_cnt - gc0 >= 2) break;
         guard++;
         if (guard > 50) timeout("rst_wait_grants");
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_req", 32'(mem_req_o), 32'd0);
      check("rst_mid_stall", 32'(stall_req_o), 32'd0);
      check("rst_mid_wdata", wdata_o, 32'h0);
      check("rst_mid_ctrl", 32'({wd_o, wreg_o, mem_we_o, mem_dout_o}), 32'h0);
      check("rst_mid_addr", mem_a_o, 32'h0);
      @(posedge clk);
      #1;
      opcode_i = OP_NOP;
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_op(OP_LOAD, 3'b010, 32'h300, 5'd9, 1'b1, 32'h0, 0, 1'b1, 32'h12345678);

      grant_pct = 70;
      rdy_low_pct = 10;
      for (int i = 0; i < 150; i++) begin
         int unsigned sel;
         logic [6:0]  op;
         logic [2:0]  f3;
         logic [31:0] addr;
         sel = $urandom_range(0, 99);
         case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
         endcase
         if (sel < 35) begin
            op = OP_LOAD;
         end else if (sel < 70) begin
            op = OP_STORE;
         end else if (sel < 80) begin
            op = ($urandom_range(0, 1) == 0) ? OP_LOAD : OP_STORE;
            case ($urandom_range(0, 2))
               0: f3 = 3'b011;
               1: f3 = 3'b110;
               default: f3 = 3'b111;
            endcase
         end else begin
            op = 7'($urandom);
            if (op == OP_LOAD || op == OP_STORE) op = OP_ADD;
         end
         addr = ($urandom_range(0, 1) == 0) ? 32'h200 + 32'($urandom_range(0, 15))
                                            : 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
         do_op(op, f3, addr, 5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)),
               1'b0, 32'h0);
      end

      @(posedge clk);
      #1;
      present = 1'b0;
      rdy = 1'b1;
      opcode_i = OP_NOP;
      repeat (3) @(posedge clk);
      #1;
      check("write_count", 32'(wr_cnt), 32'(exp_wr_cnt));
      check("expected_drained", 32'(exp_q.size()), 32'd0);
      check("mem_key_count", 32'(dut_mem.num()), 32'(ref_mem.num()));
      foreach (ref_mem[a]) check($sformatf("mem[%h]", a), 32'(rd_dut(a)), 32'(ref_mem[a]));
      finish_run();
   end
endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access stage of the five-stage RISC-V pipeline, sitting between the EX/MEM latch and the MEM/WB latch. It consumes the execute result (opcode, funct3, effective address, destination register, write data). Load and store instructions are carried out as byte-serial transfers on the shared 8-bit memory controller port; all other instructions pass straight through. While an access is in flight it holds the pipeline with a stall request.

## Interface
No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; 0 freezes the block
- opcode_i  in  7  opcode from EX/MEM
- funct3_i  in  3  funct3 from EX/MEM
- mem_addr_i  in  32  effective address (loads/stores)
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result, or store data for stores
- stall_i  in  1  downstream/other-source pipeline freeze
- wd_o  out  5  destination to MEM/WB
- wreg_o  out  1  write enable to MEM/WB
- wdata_o  out  32  writeback data to MEM/WB
- stall_req_o  out  1  hold IF..EX/MEM latches
- mem_req_o  out  1  byte access request
- mem_we_o  out  1  1 = write byte, 0 = read byte
- mem_a_o  out  32  byte address
- mem_dout_o  out  8  write byte
- mem_gnt_i  in  1  controller accepted this cycle's request
- mem_din_i  in  8  read byte, valid the cycle after its grant

## Operation
- Opcodes: LOAD 7'b0000011, STORE 7'b0100011.
  - Byte count N: funct3 000/100 → 1; 001/101 → 2; 010 → 4.
  - Any other funct3 on LOAD/STORE: no memory access; completes immediately as a non-memory op with wreg_o=0.
- Non-memory op: outputs are combinational pass-through (wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i); stall_req_o=0; FSM stays IDLE.
- FSM states IDLE, ACC, LAST, DONE; 2-bit byte counter k.
  - IDLE: on a memory op (rdy=1) → ACC, with k=0.
  - ACC: mem_req_o=1, mem_a_o=mem_addr_i+k (32-bit wrap), mem_we_o=1 for store.
    - mem_dout_o = wdata_i[8k+7:8k].
    - On mem_gnt_i: k increments. After the grant of byte N-1: load → LAST, store → DONE.
    - Without a grant, request and address are held unchanged.
  - Load capture: the byte granted in cycle t is written into buffer lane k in cycle t+1, in any state.
  - LAST: captures the final byte, then → DONE.
  - DONE: outputs carry the result and stall_req_o=0. → IDLE when stall_i=0; held in DONE while stall_i=1, so a store is never repeated.
- stall_req_o = memory op present AND state≠DONE (combinational).
- Load result assembly, little-endian:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW uses all 4 bytes.
  - wdata_o = assembled value in DONE.
- Store in DONE: wdata_o=wdata_i, wreg_o=wreg_i.
- Misaligned addresses are legal; bytes are simply consecutive.
- rdy=0: state, counter and buffer freeze; mem_req_o=0. The controller honours the same rdy and holds mem_din_i.
- Reset outputs (combinational while rst=1):
  - wd_o=0, wreg_o=0, wdata_o=0.
  - stall_req_o=0, mem_req_o=0, mem_we_o=0, mem_a_o=0, mem_dout_o=0.
  - State → IDLE, k=0, buffer=0.

## Timing
- Non-memory op: 0 added latency.
- Load, continuous grant: IDLE(1) + N ACC + LAST(1) + DONE(1) = N+3 cycles. stall_req_o is high for the first N+2 cycles.
- Store, continuous grant: N+2 cycles, stall_req_o high for N+1 cycles.
- Each cycle without a grant adds one cycle.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE exits.
- Reset mid-access aborts the access; bytes already written stay written.

## Test plan
- ADD passthrough: opcode 0110011, wdata_i=0x1234, wd_i=5 → same cycle wdata_o=0x1234, wd_o=5, stall_req_o=0, no mem_req_o.
- SW 0xDEADBEEF @0x100, gnt always 1 → writes EF,BE,AD,DE to 0x100..0x103 in cycles 1-4; DONE in cycle 5; stall_req_o high in cycles 0-4.
- LB @0x3 returning 0x80 → wdata_o=0xFFFFFF80 in DONE (cycle 3). LBU with the same data → 0x00000080.
- LH @0xFFFFFFFF, bytes 0x34 then 0x92, gnt withheld 2 cycles before byte 1 → addresses 0xFFFFFFFF then 0x00000000; wdata_o=0xFFFF9234 after 7 cycles.
- SB reaching DONE with stall_i=1 for 3 cycles → exactly one byte write; DONE held 4 cycles, stall_req_o=0 throughout.
- rst asserted during byte 2 of a LW → outputs 0 immediately, mem_req_o=0. A new LW after reset completes normally with the correct value.
